// File: rtl/lsh_pkg.sv
// Shared constants, types and helpers for the LSH mapping pipeline
// (hash_table, count_scanner, result logger).
package lsh_pkg;

  localparam int MAX_WINDOWS_IN_REFERENCE = 1024;
  localparam int LOG2_MAX_WINDOWS         = 10;
  localparam int COUNT_WIDTH              = 32;
  localparam int SKETCH_SIZE              = 64;

  typedef logic [COUNT_WIDTH-1:0] count_t;
  // One bit wider than a window id, so it can hold MAX_WINDOWS_IN_REFERENCE itself.
  typedef logic [LOG2_MAX_WINDOWS:0] win_idx_t;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} scan_state_e;

  function automatic count_t count_max(input count_t a, input count_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/count_scanner_if.sv
// Result handshake between count_scanner (master) and the result logger (slave).
interface count_scanner_if;
  import lsh_pkg::*;

  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_query_id;
  logic [31:0] best_window_id;
  count_t      best_count;
  count_t      second_count;
  logic        match_found;

  modport master (
    output result_valid, result_query_id, best_window_id,
           best_count, second_count, match_found,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_query_id, best_window_id,
           best_count, second_count, match_found,
    output result_ready
  );

endinterface

// File: rtl/count_scanner_group_reducer.sv
// Combinational top-2 reduction of one SCAN_LANES-wide group of counts,
// ignoring lanes whose window index is at or beyond the active limit.
module count_group_reducer
  import lsh_pkg::*;
#(
  parameter int SCAN_LANES = 4
) (
  input  count_t [SCAN_LANES-1:0] i_counts,
  input  win_idx_t                i_base_idx,
  input  win_idx_t                i_limit,
  output count_t                  o_top_count,
  output win_idx_t                o_top_idx,
  output count_t                  o_second_count,
  output logic                    o_group_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_top_count    = '0;
    o_top_idx      = i_base_idx;
    o_second_count = '0;
    o_group_valid  = 1'b0;
    // Ascending lane order with strict '>' keeps the lowest index on ties.
    for (int l = 0; l < SCAN_LANES; l++) begin
      if ((i_base_idx + win_idx_t'(l)) < i_limit) begin
        o_group_valid = 1'b1;
        if (i_counts[l] > o_top_count) begin
          o_second_count = o_top_count;
          o_top_count    = i_counts[l];
          o_top_idx      = i_base_idx + win_idx_t'(l);
        end else if (i_counts[l] > o_second_count) begin
          o_second_count = i_counts[l];
        end
      end
    end
  end

endmodule

// File: rtl/count_scanner.sv
// Scans the hash_table per-window hit counts SCAN_LANES entries per clock and
// reports the best window, its count, the runner-up count and a match flag.
module count_scanner
  import lsh_pkg::*;
#(
  parameter int SCAN_LANES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_count_scanner,
  input  logic                                  scan_start,
  input  logic [31:0]                           query_id,
  input  logic [31:0]                           num_ref_windows,
  input  count_t                                threshold,
  input  count_t [MAX_WINDOWS_IN_REFERENCE-1:0] count_bus,
  output logic                                  scanner_busy,
  output logic                                  dropped_start,
  count_scanner_if.master                       res
);

  scan_state_e r_state;
  win_idx_t    r_idx;
  win_idx_t    r_limit;
  count_t      r_threshold;
  logic [31:0] r_query_id;
  count_t      r_best;
  win_idx_t    r_best_id;
  count_t      r_second;

  count_t [SCAN_LANES-1:0] w_lane_counts;
  count_t   w_grp_top;
  win_idx_t w_grp_idx;
  count_t   w_grp_second;
  logic     w_grp_valid;
  logic     w_beats;
  count_t   w_new_best;
  win_idx_t w_new_best_id;
  count_t   w_new_second;
  logic     w_last_group;
  win_idx_t w_limit;

  // Full 32-bit compare so oversized window counts clamp instead of aliasing.
  assign w_limit = (num_ref_windows >= 32'(MAX_WINDOWS_IN_REFERENCE))
                 ? win_idx_t'(MAX_WINDOWS_IN_REFERENCE)
                 : num_ref_windows[LOG2_MAX_WINDOWS:0];

  for (genvar l = 0; l < SCAN_LANES; l++) begin : g_lane
    logic [LOG2_MAX_WINDOWS-1:0] w_sel;
    assign w_sel            = r_idx[LOG2_MAX_WINDOWS-1:0] + LOG2_MAX_WINDOWS'(l);
    assign w_lane_counts[l] = count_bus[w_sel];
  end

  count_group_reducer #(.SCAN_LANES(SCAN_LANES)) u_reducer (
    .i_counts       (w_lane_counts),
    .i_base_idx     (r_idx),
    .i_limit        (r_limit),
    .o_top_count    (w_grp_top),
    .o_top_idx      (w_grp_idx),
    .o_second_count (w_grp_second),
    .o_group_valid  (w_grp_valid)
  );

  // Merging two top-2 pairs: the new runner-up is the better of the two losers.
  assign w_beats       = w_grp_valid && (w_grp_top > r_best);
  assign w_new_best    = w_beats ? w_grp_top : r_best;
  assign w_new_best_id = w_beats ? w_grp_idx : r_best_id;
  assign w_new_second  = w_beats ? count_max(r_best, w_grp_second)
                                 : count_max(r_second, w_grp_valid ? w_grp_top : '0);
  assign w_last_group  = (r_idx + win_idx_t'(SCAN_LANES)) >= r_limit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge register values.
  always_ff @(posedge clk) begin
    if (reset_count_scanner) begin
      r_state              <= IDLE;
      r_idx                <= '0;
      r_limit              <= '0;
      r_threshold          <= '0;
      r_query_id           <= '0;
      r_best               <= '0;
      r_best_id            <= '0;
      r_second             <= '0;
      scanner_busy         <= 1'b0;
      dropped_start        <= 1'b0;
      res.result_valid     <= 1'b0;
      res.result_query_id  <= '0;
      res.best_window_id   <= '0;
      res.best_count       <= '0;
      res.second_count     <= '0;
      res.match_found      <= 1'b0;
    end else begin
      dropped_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (scan_start) begin
            r_query_id   <= query_id;
            r_threshold  <= threshold;
            r_limit      <= w_limit;
            r_idx        <= '0;
            r_best       <= '0;
            r_best_id    <= '0;
            r_second     <= '0;
            scanner_busy <= 1'b1;
            if (w_limit == '0) begin
              r_state             <= REPORT;
              res.result_valid    <= 1'b1;
              res.result_query_id <= query_id;
              res.best_window_id  <= '0;
              res.best_count      <= '0;
              res.second_count    <= '0;
              res.match_found     <= 1'b0;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          dropped_start <= scan_start;
          r_best        <= w_new_best;
          r_best_id     <= w_new_best_id;
          r_second      <= w_new_second;
          r_idx         <= r_idx + win_idx_t'(SCAN_LANES);
          if (w_last_group) begin
            r_state             <= REPORT;
            res.result_valid    <= 1'b1;
            res.result_query_id <= r_query_id;
            res.best_window_id  <= 32'(w_new_best_id);
            res.best_count      <= w_new_best;
            res.second_count    <= w_new_second;
            res.match_found     <= (w_new_best >= r_threshold);
          end
        end
        REPORT: begin
          dropped_start <= scan_start;
          if (res.result_ready) begin
            r_state          <= IDLE;
            res.result_valid <= 1'b0;
            scanner_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_scanner.sv
// Randomized and directed bench for count_scanner; expected results come from
// a plain max / max-of-the-rest model over the stimulus array.
module tb_count_scanner;
  import lsh_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_start;
  logic [31:0] query_id;
  logic [31:0] num_ref_windows;
  count_t      threshold;
  count_t [MAX_WINDOWS_IN_REFERENCE-1:0] bus;
  logic        busy;
  logic        dropped;

  int n_checks = 0;
  int n_errors = 0;

  count_scanner_if u_if ();

  count_scanner #(.SCAN_LANES(4)) dut (
    .clk                 (clk),
    .reset_count_scanner (reset),
    .scan_start          (scan_start),
    .query_id            (query_id),
    .num_ref_windows     (num_ref_windows),
    .threshold           (threshold),
    .count_bus           (bus),
    .scanner_busy        (busy),
    .dropped_start       (dropped),
    .res                 (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Best = largest count (first occurrence); runner-up = largest of every other entry.
  task automatic model(input int lim, output logic [31:0] b, output logic [31:0] id,
                       output logic [31:0] s);
    b = 0; id = 0; s = 0;
    for (int i = 0; i < lim; i++)
      if (bus[i] > b) begin b = bus[i]; id = i; end
    for (int i = 0; i < lim; i++)
      if (i != int'(id) && bus[i] > s) s = bus[i];
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  u_if.result_valid,    0);
    check({tag, "_busy"},   busy,                 0);
    check({tag, "_drop"},   dropped,              0);
    check({tag, "_qid"},    u_if.result_query_id, 0);
    check({tag, "_id"},     u_if.best_window_id,  0);
    check({tag, "_best"},   u_if.best_count,      0);
    check({tag, "_second"}, u_if.second_count,    0);
    check({tag, "_match"},  u_if.match_found,     0);
  endtask

  task automatic check_fields(input string tag, input logic [31:0] qid, input logic [31:0] eb,
                              input logic [31:0] eid, input logic [31:0] es, input logic em);
    check({tag, "_valid"},  u_if.result_valid,    1);
    check({tag, "_busy"},   busy,                 1);
    check({tag, "_qid"},    u_if.result_query_id, qid);
    check({tag, "_id"},     u_if.best_window_id,  eid);
    check({tag, "_best"},   u_if.best_count,      eb);
    check({tag, "_second"}, u_if.second_count,    es);
    check({tag, "_match"},  u_if.match_found,     em);
  endtask

  task automatic run_scan(input logic [31:0] nref, input logic [31:0] thr, input logic [31:0] qid,
                          input int drop_at, input int hold, input bit start_at_hs);
    int lim;
    int cycles;
    logic [31:0] eb, eid, es;
    logic em;
    lim = (nref > 32'd1024) ? 1024 : int'(nref);
    model(lim, eb, eid, es);
    em = (lim > 0) && (eb >= thr);
    @(negedge clk);
    scan_start = 1'b1; query_id = qid; num_ref_windows = nref; threshold = thr;
    @(negedge clk);
    // Scramble the start-time inputs to prove they were latched.
    scan_start = 1'b0; query_id = $urandom; num_ref_windows = $urandom; threshold = $urandom;
    cycles = 0;
    while (!u_if.result_valid && cycles < 1100) begin
      if (cycles == drop_at) scan_start = 1'b1;
      @(negedge clk);
      if (cycles == drop_at) begin
        scan_start = 1'b0;
        check("drop_in_scan", dropped, 1);
      end
      cycles++;
    end
    check("latency", cycles, (lim + 3) / 4);
    check_fields("result", qid, eb, eid, es, em);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_fields("held", qid, eb, eid, es, em);
    end
    u_if.result_ready = 1'b1;
    scan_start = start_at_hs;
    @(negedge clk);
    u_if.result_ready = 1'b0;
    scan_start = 1'b0;
    check("hs_valid", u_if.result_valid, 0);
    check("hs_drop", dropped, start_at_hs);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_drop", dropped, 0);
  endtask

  task automatic fill_random();
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < MAX_WINDOWS_IN_REFERENCE; i++) begin
      case (mode)
        0:       bus[i] = $urandom_range(0, 6);
        1:       bus[i] = $urandom;
        default: bus[i] = ($urandom_range(0, 63) == 0) ? $urandom_range(1, 20) : 0;
      endcase
    end
  endtask

  initial begin
    int seen;
    logic [31:0] nref;
    reset = 1'b1; scan_start = 1'b0; u_if.result_ready = 1'b0;
    query_id = '0; num_ref_windows = '0; threshold = '0; bus = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Unique peak with 20 cycles of backpressure.
    bus = '0; bus[700] = 9;
    run_scan(1024, 5, 32'h0000_0011, -1, 20, 0);
    // Tie keeps the lowest index; runner-up equals best.
    bus = '0; bus[3] = 7; bus[5] = 7; bus[900] = 4;
    run_scan(1024, 8, 32'h0000_0022, -1, 0, 0);
    // Limit clipping and clamping.
    bus = '0; bus[9] = 2; bus[10] = 50;
    run_scan(10, 2, 32'h0000_0033, -1, 0, 0);
    bus[1023] = 60;
    run_scan(5000, 1, 32'h0000_0044, -1, 0, 0);
    // Empty scan and zero threshold.
    run_scan(0, 0, 32'h0000_0055, -1, 2, 0);
    bus = '0;
    run_scan(4, 0, 32'h0000_0066, -1, 0, 0);
    // Start during SCAN and coincident with the REPORT handshake.
    fill_random();
    run_scan(1024, 3, 32'hCAFE_0001, 10, 3, 1);

    // Reset mid-scan aborts with no result, then a fresh scan works.
    fill_random();
    @(negedge clk);
    scan_start = 1'b1; num_ref_windows = 1024; query_id = 32'hDEAD; threshold = 1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("rst_mid");
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (u_if.result_valid) seen = 1;
    end
    check("rst_no_result", seen, 0);
    run_scan(700, 4, 32'hBEEF_0002, -1, 0, 0);

    for (int t = 0; t < 12; t++) begin
      fill_random();
      case ($urandom_range(0, 9))
        0:       nref = 0;
        1:       nref = 1024 + $urandom_range(1, 100000);
        2:       nref = $urandom;
        default: nref = $urandom_range(1, 1024);
      endcase
      run_scan(nref, $urandom_range(0, 20), $urandom,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
               $urandom_range(0, 5), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_scanner.md
Name: count_scanner

Overview:
- Hardware reader for the hash_table `count_bus`.
- After a read window is queried, `count_scanner` scans the per-reference-window hit counts. It reports:
  - the best-matching reference window id and its count;
  - the runner-up count;
  - a threshold-based match flag.
- It replaces the software-side result inspection. It sits downstream of hash_table and upstream of the mapping/result logger, with a valid/ready output handshake.

Parameters:
- MAX_WINDOWS_IN_REFERENCE, 1024: number of `count_bus` entries.
- LOG2_MAX_WINDOWS, 10: index width of a window id inside the bus.
- COUNT_WIDTH, 32: width of each `count_bus` entry.
- SCAN_LANES, 4: entries examined per clock. Must be a power of two that divides MAX_WINDOWS_IN_REFERENCE.

Ports:
- clk  in  1  system clock, rising edge.
- reset_count_scanner  in  1  synchronous, active-high reset.
- scan_start  in  1  one-cycle pulse: `count_bus` holds the final counts for query `query_id`.
- query_id  in  32  read window id, latched on an accepted start.
- num_ref_windows  in  32  number of valid reference windows, latched on start.
- threshold  in  COUNT_WIDTH  minimum count for a match, latched on start.
- count_bus  in  COUNT_WIDTH x MAX_WINDOWS_IN_REFERENCE  hit count per reference window.
- scanner_busy  out  1  high in SCAN and REPORT.
- result_valid  out  1  result fields are valid.
- result_ready  in  1  consumer accepts the result.
- result_query_id  out  32  latched `query_id`.
- best_window_id  out  32  index of the highest count; zero-extended.
- best_count  out  COUNT_WIDTH  highest count.
- second_count  out  COUNT_WIDTH  highest count among all other entries.
- match_found  out  1  `best_count` >= `threshold` and limit > 0.
- dropped_start  out  1  one-cycle pulse: `scan_start` arrived while not IDLE.

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset `reset_count_scanner` is synchronous and active-high. On reset:
  - state = IDLE;
  - all outputs = 0;
  - internal index, best and second registers = 0.
  - Reset mid-SCAN or mid-REPORT aborts the scan, and no result is emitted.
- **State machine.** IDLE -> SCAN -> REPORT -> IDLE.
- **IDLE.**
  - `scan_start` = 1 latches `query_id` and `threshold`, plus limit = min(`num_ref_windows`, MAX_WINDOWS_IN_REFERENCE).
  - It also clears idx, best, best_id and second to 0.
  - Next state is SCAN, or REPORT directly if limit = 0.
- **SCAN.**
  - Each edge processes entries idx .. idx+SCAN_LANES-1, then idx += SCAN_LANES.
  - Entries with index >= limit are ignored.
  - After the group containing index limit-1 is processed, go to REPORT.
- **Result equivalence.** The result must equal a sequential scan in ascending index order using these rules:
  - if c > best: second = best, best = c, best_id = index;
  - else if c > second: second = c.
  - Consequences: ties keep the lowest index; `second_count` may equal `best_count`.
- **REPORT.**
  - `result_valid` = 1 and all result fields are held stable.
  - The state is held until `result_ready` = 1 on an edge, then returns to IDLE with `result_valid` = 0 next cycle.
  - `result_ready` while not `result_valid` is ignored.
- **Latency.** With the start accepted on edge E0, `result_valid` rises after E0 + ceil(limit/SCAN_LANES) edges. With limit = 0 it rises right after E0, and reports `best_count` = 0, `best_window_id` = 0, `second_count` = 0, `match_found` = 0.
- **Dropped starts.** `scan_start` in SCAN or REPORT is not queued. `dropped_start` pulses on the next cycle and the latched values are unchanged. This includes the cycle in which the REPORT handshake completes.
- **Threshold.** `threshold` = 0 with limit > 0 gives `match_found` = 1.
- **Integration requirement.** `count_bus` must stay stable from the start edge until the result handshake. hash_table must not see `is_query` or a reset during a scan. The scanner does not check this.
- **Arithmetic.**
  - Comparisons are unsigned COUNT_WIDTH.
  - idx is LOG2_MAX_WINDOWS+1 bits, so it cannot wrap at 1024.
  - limit compare uses the full 32-bit `num_ref_windows`, so values > MAX are clamped.

Decomposition:
- **Package `lsh_pkg`:**
  - constants MAX_WINDOWS_IN_REFERENCE, LOG2_MAX_WINDOWS, COUNT_WIDTH, SKETCH_SIZE;
  - typedef `count_t` (logic [COUNT_WIDTH-1:0]);
  - typedef `win_idx_t`;
  - enum `scan_state_e` {IDLE, SCAN, REPORT}.
- **Sub-module `count_group_reducer`** (combinational):
  - inputs: SCAN_LANES counts, base index, limit;
  - outputs: group top count, its lowest index, group second count, and a group-valid flag.
- **Top module:** holds the FSM and merges the group result into the running best/second using the same ordering rules.

Test Plan:
- **Unique peak:** limit=1024, all counts 0 except [700]=9, threshold=5 -> after 256 cycles `best_window_id`=700, `best_count`=9, `second_count`=0, `match_found`=1.
- **Tie and runner-up:** [3]=7, [5]=7, [900]=4, limit=1024 -> `best_window_id`=3, `best_count`=7, `second_count`=7.
- **Limit clipping:** limit=10, [9]=2, [10]=50 -> `result_valid` after 3 cycles, `best_window_id`=9, `best_count`=2. `num_ref_windows`=5000 -> clamped to 1024.
- **Empty:** limit=0 -> `result_valid` 1 cycle after start with all fields 0 and `match_found`=0. Threshold 0 with limit=4, all zeros -> `match_found`=1, `best_window_id`=0.
- **Backpressure and drops:**
  - hold `result_ready`=0 for 20 cycles -> fields stable;
  - `scan_start` during SCAN -> `dropped_start` pulse and result unchanged;
  - start coincident with the REPORT handshake -> dropped.
- **Reset mid-scan:** reset at SCAN cycle 100 -> all outputs 0 next cycle and no `result_valid`; a new start scans correctly.
